// File: rtl/commit_trace_checker.sv
// Checks the processor commit stream against an expected-record stream.
// Commit beats are buffered in a small FIFO and expanded into REG/LOAD/STORE/HALT records.
module commit_trace_checker #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             c_regwrite,
   input  logic [2:0]       c_wreg,
   input  logic [15:0]      c_wdata,
   input  logic             c_memread,
   input  logic             c_memwrite,
   input  logic [15:0]      c_addr,
   input  logic [15:0]      c_mem_din,
   input  logic [15:0]      c_mem_dout,
   input  logic             c_halt,
   input  logic             exp_valid,
   output logic             exp_ready,
   input  logic [1:0]       exp_kind,
   input  logic [15:0]      exp_a,
   input  logic [15:0]      exp_b,
   output logic             done,
   output logic             fail,
   output logic             overflow,
   output logic [CNT_W-1:0] err_index,
   output logic [15:0]      err_exp_a,
   output logic [15:0]      err_exp_b,
   output logic [15:0]      err_act_a,
   output logic [15:0]      err_act_b,
   output logic [1:0]       err_kind,
   output logic [CNT_W-1:0] rec_count,
   output logic [CNT_W-1:0] inst_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);

   typedef struct packed {
      logic        halt;
      logic        memwrite;
      logic        memread;
      logic        regwrite;
      logic [2:0]  wreg;
      logic [15:0] wdata;
      logic [15:0] addr;
      logic [15:0] memDin;
      logic [15:0] memDout;
   } beat_t;

   typedef enum logic [2:0] {IDLE, REG, LOAD, STORE, HALT, DONE, FAIL} state_t;

   // Lowest set bit of a {halt, store, load, reg} mask, i.e. the next record in commit order.
   function automatic logic [1:0] firstKind(input logic [3:0] mask);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   function automatic state_t kindState(input logic [1:0] k);
      return state_t'({1'b0, k} + 3'd1);
   endfunction

   beat_t               fifoMem [FIFO_DEPTH];
   logic [AW:0]         wrPtrReg, rdPtrReg;
   state_t              stateReg, stateNext;
   logic                doneReg, failReg, overflowReg;
   logic [CNT_W-1:0]    recCountReg, instCountReg, errIndexReg;
   logic [15:0]         errExpAReg, errExpBReg, errActAReg, errActBReg;
   logic [1:0]          errKindReg;

   beat_t               incoming, headBeat;
   logic [AW:0]         fillLevel;
   logic [AW-1:0]       rdNextAddr;
   logic                fifoEmpty, fifoFull, anyStrobe, enqReq, enq, deq, ovf;
   logic                recMatch, recMismatch, kindOk, isKindState;
   logic [1:0]          curKind;
   logic [3:0]          headMask, laterMask, nextMask;
   logic [15:0]         actA, actB;

   assign incoming = beat_t'{halt: c_halt, memwrite: c_memwrite, memread: c_memread,
                             regwrite: c_regwrite, wreg: c_wreg, wdata: c_wdata,
                             addr: c_addr, memDin: c_mem_din, memDout: c_mem_dout};

   assign fillLevel  = wrPtrReg - rdPtrReg;
   assign fifoEmpty  = (fillLevel == '0);
   assign fifoFull   = (fillLevel == FULL_LEVEL);
   assign rdNextAddr = rdPtrReg[AW-1:0] + 1'b1;
   assign headBeat   = fifoMem[rdPtrReg[AW-1:0]];
   assign headMask   = {headBeat.halt, headBeat.memwrite, headBeat.memread, headBeat.regwrite};
   assign nextMask   = {fifoMem[rdNextAddr].halt, fifoMem[rdNextAddr].memwrite,
                        fifoMem[rdNextAddr].memread, fifoMem[rdNextAddr].regwrite};
   assign laterMask  = headMask & (4'b1110 << curKind);

   assign anyStrobe = c_regwrite | c_memread | c_memwrite | c_halt;
   assign enqReq    = anyStrobe && !doneReg && !failReg;
   // A pop in the same cycle frees the slot, so a full FIFO only overflows without one.
   assign enq       = enqReq && (!fifoFull || deq);
   assign ovf       = enqReq && fifoFull && !deq;

   assign isKindState = (stateReg inside {REG, LOAD, STORE, HALT});
   assign exp_ready   = exp_valid && isKindState;

   always_comb begin
      curKind = 2'd0;
      actA    = 16'h0000;
      actB    = 16'h0000;
      case (stateReg)
         REG:   begin curKind = 2'd0; actA = {13'b0, headBeat.wreg}; actB = headBeat.wdata;   end
         LOAD:  begin curKind = 2'd1; actA = headBeat.addr;          actB = headBeat.memDout; end
         STORE: begin curKind = 2'd2; actA = headBeat.addr;          actB = headBeat.memDin;  end
         HALT:  curKind = 2'd3;
         default: ;
      endcase
   end

   assign kindOk = (exp_kind == curKind) &&
                   ((stateReg == HALT) || ((exp_a == actA) && (exp_b == actB)));

   always_comb begin
      stateNext   = stateReg;
      deq         = 1'b0;
      recMatch    = 1'b0;
      recMismatch = 1'b0;
      case (stateReg)
         IDLE: if (!fifoEmpty) stateNext = kindState(firstKind(headMask));
         REG, LOAD, STORE, HALT: begin
            if (exp_valid) begin
               if (kindOk) begin
                  recMatch = 1'b1;
                  if (stateReg == HALT) begin
                     deq       = 1'b1;
                     stateNext = DONE;
                  end else if (|laterMask) begin
                     stateNext = kindState(firstKind(laterMask));
                  end else begin
                     // Chain straight into the following beat when one is already buffered.
                     deq       = 1'b1;
                     stateNext = (fillLevel > ONE_LEVEL) ? kindState(firstKind(nextMask)) : IDLE;
                  end
               end else begin
                  recMismatch = 1'b1;
                  stateNext   = FAIL;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (enq) fifoMem[wrPtrReg[AW-1:0]] <= incoming;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtrReg     <= '0;
         rdPtrReg     <= '0;
         stateReg     <= IDLE;
         doneReg      <= 1'b0;
         failReg      <= 1'b0;
         overflowReg  <= 1'b0;
         recCountReg  <= '0;
         instCountReg <= '0;
         errIndexReg  <= '0;
         errExpAReg   <= '0;
         errExpBReg   <= '0;
         errActAReg   <= '0;
         errActBReg   <= '0;
         errKindReg   <= '0;
      end else begin
         stateReg <= ovf ? FAIL : stateNext;
         if (enq) begin
            wrPtrReg     <= wrPtrReg + 1'b1;
            instCountReg <= instCountReg + 1'b1;
         end
         if (deq) rdPtrReg <= rdPtrReg + 1'b1;
         if (recMatch) recCountReg <= recCountReg + 1'b1;
         if (recMatch && stateReg == HALT) doneReg <= 1'b1;
         if (recMismatch || ovf) begin
            failReg     <= 1'b1;
            errIndexReg <= recCountReg;
         end
         if (ovf) overflowReg <= 1'b1;
         if (recMismatch) begin
            errExpAReg <= exp_a;
            errExpBReg <= exp_b;
            errActAReg <= actA;
            errActBReg <= actB;
            errKindReg <= curKind;
         end
      end
   end

   assign done       = doneReg;
   assign fail       = failReg;
   assign overflow   = overflowReg;
   assign err_index  = errIndexReg;
   assign err_exp_a  = errExpAReg;
   assign err_exp_b  = errExpBReg;
   assign err_act_a  = errActAReg;
   assign err_act_b  = errActBReg;
   assign err_kind   = errKindReg;
   assign rec_count  = recCountReg;
   assign inst_count = instCountReg;

endmodule

// File: doc/commit_trace_checker.md
Name: commit_trace_checker

Overview:
- In-hardware consumer of the processor commit stream (register writes, loads, stores, halt). Compares each commit against an expected-record stream supplied over a valid/ready port.
- Sits beside proc_hier in self-checking simulation and FPGA bring-up. Reports pass/fail, the first mismatch and event counts.
- Record order per commit cycle is fixed: REG, then LOAD, then STORE, then HALT.

Parameters:
- FIFO_DEPTH, 8, commit-beat buffer entries (power of two, >=2)
- CNT_W, 16, width of the record and instruction counters

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- c_regwrite  in  1  register write commits this cycle
- c_wreg  in  3  destination register
- c_wdata  in  16  register write data
- c_memread  in  1  load commits this cycle
- c_memwrite  in  1  store commits this cycle
- c_addr  in  16  memory address
- c_mem_din  in  16  store data
- c_mem_dout  in  16  load data
- c_halt  in  1  halt commits this cycle
- exp_valid  in  1  expected record available
- exp_ready  out  1  expected record consumed this cycle
- exp_kind  in  2  0=REG, 1=LOAD, 2=STORE, 3=HALT
- exp_a  in  16  REG: {13'b0, reg}; LOAD/STORE: address; HALT: don't care
- exp_b  in  16  data; HALT: don't care
- done  out  1  sticky; HALT record matched
- fail  out  1  sticky; mismatch or overflow
- overflow  out  1  sticky; commit beat dropped because the FIFO was full
- err_index  out  CNT_W  record index of the first failure
- err_exp_a, err_exp_b, err_act_a, err_act_b  out  16 each  fields of the first mismatch
- err_kind  out  2  actual kind at the first mismatch
- rec_count  out  CNT_W  records matched
- inst_count  out  CNT_W  beats enqueued (a beat has any c_* strobe set)

Behaviour:
- Reset (rst=0, asynchronous): all outputs, counters, FIFO pointers and FSM go to 0/IDLE. exp_ready=0. Reset mid-operation discards all buffered beats.
- Enqueue:
  - Any of c_regwrite, c_memread, c_memwrite, c_halt high on a clk edge while not done and not fail enqueues one beat: all strobes plus all data fields.
  - inst_count increments by 1 per enqueued beat.
  - Cycles with no strobe enqueue nothing.
- FIFO full plus an incoming beat: beat dropped; overflow=1 and fail=1; err_index=rec_count; err_* hold 0. Simultaneous dequeue and enqueue on a full FIFO is not overflow.
- FSM states: IDLE, REG, LOAD, STORE, HALT, DONE, FAIL.
  - IDLE: FIFO non-empty -> go to the first set kind of the head beat in REG/LOAD/STORE/HALT order.
  - Each kind state waits for exp_valid. exp_ready pulses 1 only in the cycle exp_valid=1 and the FSM is in a kind state.
  - Compare exp_kind against the state's kind, exp_a against the actual a, exp_b against the actual b (HALT compares kind only).
  - Match: rec_count+1, then go to the next set kind of the same beat. If none remain, pop the beat and go to IDLE, or straight to the next beat's first kind if the FIFO is non-empty (no bubble).
  - HALT match: done=1, go to DONE.
  - Mismatch: latch err_* and err_index=rec_count, fail=1, go to FAIL. rec_count is not incremented.
- DONE and FAIL are terminal until reset. In both, exp_ready=0 and enqueue is disabled. Commits after halt are ignored and are not overflow.
- Latency: a beat enqueued at edge N is compared no earlier than edge N+1. With exp_valid held high, each record takes 1 cycle.
- Counters wrap modulo 2^CNT_W.
- Beat with a LOAD and a STORE in the same cycle: both records are checked, LOAD first.
- The FIFO drains one record per cycle at most; sustained commits faster than that overflow.

Test Plan:
- REG r3=0x1234 commit; expected {0,0x0003,0x1234} then HALT commit and expected HALT -> exp_ready pulses twice, rec_count=2, done=1, fail=0, inst_count=2.
- One beat with regwrite r1=0x00AA and memread addr 0x0040 dout 0x00AA; expected REG then LOAD -> 2 records consumed on consecutive cycles, rec_count=2.
- STORE addr 0x0010 din 0x5555; expected STORE addr 0x0010 data 0x5554 -> fail=1, err_index=0, err_exp_b=0x5554, err_act_b=0x5555, err_kind=2, FSM in FAIL, exp_ready stays 0.
- exp_valid held 0 while 9 beats commit (FIFO_DEPTH=8) -> overflow=1, fail=1, inst_count=8.
- exp_valid toggling 1/0 every cycle across 4 REG beats -> all match, rec_count=4, no extra records consumed.
- rst driven low mid-stream with 3 beats queued -> all outputs 0 immediately (asynchronously); after release a fresh REG/HALT sequence passes with done=1.
